instr_encoder: RTL and testbench

- Inverse of the instruction decoder: takes ALU-level requests (alu op code, register numbers, immediate) and produces 32-bit MIPS instruction words, each tagged with an instruction-memory address.
- Feeds the instruction-memory loader and testbench program builders.
- Requests enter through a valid/ready handshake and are encoded in one cycle.
- Encoded words pass through a small FIFO to a valid/ready output.

---
 rtl/instr_enc_pkg.sv | 36 +++
 rtl/instr_enc_fifo.sv | 72 +++++++
 rtl/instr_encoder.sv | 130 +++++++++++++
 tb/tb_instr_encoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared constants and types for the instruction encoder.
//   - ALU op codes (same encoding the decoder produces)
//   - MIPS opcode / funct field constants
//   - request struct and {instr, addr} FIFO entry struct
package instr_enc_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic [2:0]  op;
    logic        imm_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
  } enc_req_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } fifo_entry_t;

endpackage

// File: rtl/instr_enc_fifo.sv
// instr_enc_fifo: synchronous FIFO of {instr, addr} entries.
// Ports:
//   clk, rst_n (async low), flush (sync clear)
//   push/push_data : write, ignored when full
//   pop            : read, ignored when empty
//   head           : entry at read pointer (valid when !empty)
//   full/empty/count
module instr_enc_fifo
  import instr_enc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fifo_entry_t   push_data,
  input  logic          pop,
  output fifo_entry_t   head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: head is only consumed when count != 0.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: turns ALU-level requests into 32-bit MIPS words tagged
// with sequential instruction-memory addresses, queued in a small FIFO.
// Ports:
//   clk, rst_n (async low), flush (sync clear of FIFO + address counter)
//   in_valid/in_ready, in_op, in_imm_sel, in_rs, in_rt, in_rd, in_imm
//   out_valid/out_ready, out_instr, out_addr
//   err     : one-cycle pulse after an illegal request was dropped
//   err_cnt : saturating illegal-request count
// Build option: define INSTR_ENC_ERR_CNT_EN to enable err_cnt; otherwise 0.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic        in_imm_sel,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  enc_req_t      req;
  fifo_entry_t   wr_ent, head;
  logic [5:0]    funct;
  logic          legal, accept, push, pop;
  logic [31:0]   word;
  logic [31:0]   addr_q, addr_d;
  logic          err_q, err_d;
  logic          fifo_empty, fifo_full_unused;
  logic [CW-1:0] fifo_cnt;

  assign req = '{op: in_op, imm_sel: in_imm_sel, rs: in_rs, rt: in_rt,
                 rd: in_rd, imm: in_imm};

  always_comb begin
    funct = FN_ADD;
    legal = 1'b1;
    case (req.op)
      OP_ADD:  funct = FN_ADD;
      OP_AND:  funct = FN_AND;
      OP_OR:   funct = FN_OR;
      OP_SUB:  funct = FN_SUB;
      OP_SLT:  funct = FN_SLT;
      default: legal = 1'b0;
    endcase
    // Only addi exists as an immediate form.
    if (req.imm_sel && req.op != OP_ADD) legal = 1'b0;
    word = req.imm_sel ? {OPC_ADDI, req.rs, req.rt, req.imm}
                       : {OPC_RTYPE, req.rs, req.rt, req.rd, 5'b00000, funct};
  end

  // in_ready comes from registered count only, keeping out_ready off the
  // input-side path.
  assign in_ready = (fifo_cnt < CW'(DEPTH));
  assign accept   = in_valid & in_ready;
  assign push     = accept & legal & ~flush;
  assign pop      = out_valid & out_ready;
  assign wr_ent   = '{instr: word, addr: addr_q};

  always_comb begin
    addr_d = addr_q;
    if (flush)     addr_d = ADDR_BASE;
    else if (push) addr_d = addr_q + 32'd4;
    // flush swallows the request entirely, including its error report.
    err_d = accept & ~legal & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= ADDR_BASE;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  instr_enc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (wr_ent),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign out_valid = ~fifo_empty;
  assign out_instr = out_valid ? head.instr : 32'd0;
  assign out_addr  = out_valid ? head.addr  : 32'd0;
  assign err       = err_q;

`ifdef INSTR_ENC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts err pulses; survives flush, cleared only by reset.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_q && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder; expected words are hand-computed.
// ADDR_BASE is placed near the top of the address space so address wrap
// is exercised.
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'hFFFF_FFF0;
`ifdef INSTR_ENC_ERR_CNT_EN
  localparam logic [7:0] ERRC2  = 8'd2;
  localparam logic [7:0] ERRSAT = 8'hFF;
`else
  localparam logic [7:0] ERRC2  = 8'd0;
  localparam logic [7:0] ERRSAT = 8'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_imm_sel;
  logic [2:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic        out_valid, out_ready, err;
  logic [31:0] out_instr, out_addr;
  logic [7:0]  err_cnt;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] nxt;
  logic [63:0] q[$];

  instr_encoder #(.DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_imm_sel(in_imm_sel), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic sel, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm);
    in_valid = 1'b1; in_op = op; in_imm_sel = sel;
    in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // R-type add with rs=1, rt=2, variable rd.
  function automatic logic [31:0] add12(input logic [4:0] rd);
    return {6'b000000, 5'd1, 5'd2, rd, 5'b00000, 6'b100000};
  endfunction

  task automatic pop_chk(input string tag, input logic [31:0] ei, input logic [31:0] ea);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_ins"}, out_instr, ei);
    chk({tag, "_adr"}, out_addr, ea);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    idle(); req(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 16'd0); idle();
    #12;
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_ins", out_instr, 32'd0);
    chk("rst_adr", out_addr, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cnt", {24'd0, err_cnt}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    step();

    // 1: single add, one-cycle latency
    nxt = BASE;
    req(3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 16'd0); step(); idle();
    pop_chk("t1", 32'h0022_1820, nxt); nxt += 4;
    chk("t1_empty", {31'd0, out_valid}, 32'd0);

    // 2: addi then sub
    req(3'b000, 1'b1, 5'd0, 5'd5, 5'd31, 16'h0010); step();
    req(3'b011, 1'b0, 5'd5, 5'd6, 5'd4, 16'd0); step(); idle();
    pop_chk("t2a", 32'h2005_0010, nxt); nxt += 4;
    pop_chk("t2b", 32'h00A6_2022, nxt); nxt += 4;

    // 3: slt, illegal or-immediate, illegal op 101
    req(3'b111, 1'b0, 5'd9, 5'd10, 5'd8, 16'd0); step();
    chk("t3_err0", {31'd0, err}, 32'd0);
    req(3'b010, 1'b1, 5'd9, 5'd10, 5'd8, 16'h1234); step();
    chk("t3_err1", {31'd0, err}, 32'd1);
    req(3'b101, 1'b0, 5'd9, 5'd10, 5'd8, 16'd0); step(); idle();
    chk("t3_err2", {31'd0, err}, 32'd1);
    step();
    chk("t3_err3", {31'd0, err}, 32'd0);
    pop_chk("t3_slt", 32'h012A_402A, nxt); nxt += 4;
    chk("t3_only", {31'd0, out_valid}, 32'd0);
    req(3'b100, 1'b0, 5'd1, 5'd2, 5'd3, 16'd0); step();
    req(3'b010, 1'b0, 5'd1, 5'd2, 5'd3, 16'd0); step(); idle();
    pop_chk("t3_and", 32'h0022_1824, nxt); nxt += 4;
    pop_chk("t3_or", 32'h0022_1825, nxt); nxt += 4;
    chk("t3_cnt", {24'd0, err_cnt}, {24'd0, ERRC2});

    // 4: backpressure, DEPTH+1 requests
    for (int i = 0; i <= DEPTH; i++) begin
      req(3'b000, 1'b0, 5'd1, 5'd2, 5'(i), 16'd0);
      chk($sformatf("t4_rdy%0d", i), {31'd0, in_ready}, (i < DEPTH) ? 32'd1 : 32'd0);
      step();
    end
    idle();
    chk("t4_hold1", out_instr, add12(5'd0));
    step();
    chk("t4_hold2", out_instr, add12(5'd0));
    for (int i = 0; i < DEPTH; i++) begin
      pop_chk($sformatf("t4_p%0d", i), add12(5'(i)), nxt); nxt += 4;
    end
    chk("t4_empty", {31'd0, out_valid}, 32'd0);

    // 5: full FIFO, continuous push and pop across pointer wrap
    for (int i = 0; i < DEPTH; i++) begin
      req(3'b000, 1'b0, 5'd1, 5'd2, 5'(16 + i), 16'd0); step();
      q.push_back({add12(5'(16 + i)), nxt}); nxt += 4;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      logic do_push;
      req(3'b000, 1'b0, 5'd1, 5'd2, 5'(c), 16'd0);
      do_push = (q.size() < DEPTH);
      chk($sformatf("t5_rdy%0d", c), {31'd0, in_ready}, {31'd0, do_push});
      if (q.size() > 0) begin
        chk($sformatf("t5_ins%0d", c), out_instr, q[0][63:32]);
        chk($sformatf("t5_adr%0d", c), out_addr, q[0][31:0]);
        void'(q.pop_front());
      end
      if (do_push) begin
        q.push_back({add12(5'(c)), nxt}); nxt += 4;
      end
      step();
    end
    idle();
    for (int g = 0; g < 2 * DEPTH && q.size() > 0; g++) begin
      chk($sformatf("t5_dins%0d", g), out_instr, q[0][63:32]);
      chk($sformatf("t5_dadr%0d", g), out_addr, q[0][31:0]);
      void'(q.pop_front());
      step();
    end
    out_ready = 1'b0;
    chk("t5_empty", {31'd0, out_valid}, 32'd0);

    // 6a: flush with 3 queued plus a same-cycle request
    for (int i = 0; i < 3; i++) begin
      req(3'b000, 1'b0, 5'd1, 5'd2, 5'(20 + i), 16'd0); step();
    end
    req(3'b000, 1'b0, 5'd1, 5'd2, 5'd30, 16'd0); flush = 1'b1; step();
    flush = 1'b0; idle();
    chk("t6_vld", {31'd0, out_valid}, 32'd0);
    chk("t6_err", {31'd0, err}, 32'd0);
    chk("t6_rdy", {31'd0, in_ready}, 32'd1);
    req(3'b110, 1'b0, 5'd1, 5'd2, 5'd3, 16'd0); flush = 1'b1; step();
    flush = 1'b0; idle();
    chk("t6_ferr", {31'd0, err}, 32'd0);
    step();
    req(3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 16'd0); step(); idle();
    pop_chk("t6_post", 32'h0022_1820, BASE);
    chk("t6_cnt", {24'd0, err_cnt}, {24'd0, ERRC2});

    // err_cnt saturation under sustained illegal traffic
    req(3'b110, 1'b0, 5'd0, 5'd0, 5'd0, 16'd0);
    for (int i = 0; i < 260; i++) step();
    idle(); step(); step();
    chk("sat_cnt", {24'd0, err_cnt}, {24'd0, ERRSAT});
    chk("sat_empty", {31'd0, out_valid}, 32'd0);

    // 6b: async reset mid-stream
    for (int i = 0; i < 3; i++) begin
      req(3'b000, 1'b0, 5'd1, 5'd2, 5'(20 + i), 16'd0); step();
    end
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("t6r_vld", {31'd0, out_valid}, 32'd0);
    chk("t6r_ins", out_instr, 32'd0);
    chk("t6r_adr", out_addr, 32'd0);
    chk("t6r_cnt", {24'd0, err_cnt}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();
    req(3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 16'd0); step(); idle();
    pop_chk("t6r_post", 32'h0022_1820, BASE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
